rt_block_seq: RTL and testbench

RT_BLOCK_SEQ -- requirements
Module: rt_block_seq

---
 rtl/rt_pkg.sv | 28 ++
 rtl/rt_shift_tracker.sv | 41 ++++
 rtl/rt_block_seq.sv | 159 +++++++++++++++
 tb/tb_rt_block_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared types for the racetrack block sequencer: op codes, FSM states, segment geometry.
package rt_pkg;

  typedef enum logic [1:0] {
    OP_READ     = 2'b00,
    OP_WRITE    = 2'b01,
    OP_LIM_NAND = 2'b10,
    OP_LIM_NOR  = 2'b11
  } rt_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } rt_state_e;

  // Segment length: domains served by one access port.
  function automatic int unsigned seg_len(input int unsigned nb, input int unsigned np);
    return nb / np;
  endfunction

  function automatic int unsigned off_bits(input int unsigned l);
    return (l > 1) ? $clog2(l) : 1;
  endfunction

endpackage

// File: rtl/rt_shift_tracker.sv
// Shared racetrack shift offset: one step per enabled cycle toward the target, never wraps.
// Zero latency on direction/arrive flags; offset updates on the following edge.
module rt_shift_tracker #(
  parameter int unsigned OW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [OW-1:0] i_target,
  output logic          o_fwd,
  output logic          o_bwd,
  output logic          o_aligned,
  output logic          o_arrive
);

  localparam logic [OW-1:0] ONE = OW'(1);

  logic [OW-1:0] r_off;
  logic          w_ahead;
  logic          w_behind;

  assign w_ahead   = (i_target > r_off);
  assign w_behind  = (i_target < r_off);
  assign o_fwd     = i_en & w_ahead;
  assign o_bwd     = i_en & w_behind;
  assign o_aligned = (i_target == r_off);
  // True on the last shift step, so the FSM can move on right after it.
  assign o_arrive  = (o_fwd & ((r_off + ONE) == i_target)) |
                     (o_bwd & ((r_off - ONE) == i_target));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_off <= '0;
    end else if (o_fwd) begin
      r_off <= r_off + ONE;
    end else if (o_bwd) begin
      r_off <= r_off - ONE;
    end
  end

endmodule

// File: rtl/rt_block_seq.sv
// Racetrack block sequencer: shift to port offset, one-cycle array access, held response.
// Logic-in-memory ops execute only when RT_LIM_EN is defined; otherwise they return an error.
module rt_block_seq
  import rt_pkg::*;
#(
  parameter int unsigned NB  = 32,
  parameter int unsigned NP  = 8,
  parameter int unsigned NR  = 4,
  parameter int unsigned NMU = 8,
  localparam int unsigned W  = NR * NMU,
  localparam int unsigned AW = $clog2(NB)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [1:0]    req_op_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [W-1:0]  req_wdata_i,
  input  logic [NMU-1:0] req_umask_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [W-1:0]  rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          sft_fwd_o,
  output logic          sft_bwd_o,
  output logic [NB-1:0] word_lines_o,
  output logic          write_en_data_o,
  output logic [W-1:0]  write_data_o,
  output logic [W-1:0]  write_mask_o,
  output logic          rd_current_o,
  output logic          lim_en_o,
  output logic          nand_norn_o,
  input  logic [W-1:0]  array_rdata_i
);

  localparam int unsigned L  = seg_len(NB, NP);
  localparam int unsigned OW = off_bits(L);

`ifdef RT_LIM_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif

  rt_state_e      r_state;
  rt_state_e      w_state_nxt;
  rt_op_e         r_op;
  logic [AW-1:0]  r_addr;
  logic [W-1:0]   r_wdata;
  logic [NMU-1:0] r_umask;
  logic [W-1:0]   r_rdata;
  logic           r_err;

  logic           w_accept;
  logic           w_lim_reject;
  logic           w_access;
  logic [OW-1:0]  w_in_t;
  logic [OW-1:0]  w_lat_t;
  logic [OW-1:0]  w_target;
  logic           w_fwd;
  logic           w_bwd;
  logic           w_aligned;
  logic           w_arrive;
  logic [NB-1:0]  w_wl;
  logic [W-1:0]   w_mask_full;

  assign w_accept     = req_valid_i & (r_state == ST_IDLE);
  assign w_lim_reject = req_op_i[1] & ~LIM_EN;
  assign w_access     = (r_state == ST_ACCESS);
  assign w_in_t       = OW'(32'(req_addr_i) % L);
  assign w_lat_t      = OW'(32'(r_addr) % L);
  // In IDLE the tracker compares against the incoming address to pick SHIFT vs ACCESS.
  assign w_target     = (r_state == ST_IDLE) ? w_in_t : w_lat_t;

  rt_shift_tracker #(
    .OW(OW)
  ) u_tracker (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_en      (r_state == ST_SHIFT),
    .i_target  (w_target),
    .o_fwd     (w_fwd),
    .o_bwd     (w_bwd),
    .o_aligned (w_aligned),
    .o_arrive  (w_arrive)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_lim_reject)   w_state_nxt = ST_RESP;
          else if (w_aligned) w_state_nxt = ST_ACCESS;
          else                w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT:   if (w_arrive || w_aligned) w_state_nxt = ST_ACCESS;
      ST_ACCESS:  w_state_nxt = (r_op == OP_WRITE) ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_RESP;
      ST_RESP:    if (rsp_ready_i) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_op    <= OP_READ;
      r_addr  <= '0;
      r_wdata <= '0;
      r_umask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op    <= rt_op_e'(req_op_i);
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_umask <= req_umask_i;
        r_err   <= w_lim_reject;
        if (w_lim_reject) r_rdata <= '0;
      end
      if (r_state == ST_CAPTURE) r_rdata <= array_rdata_i;
    end
  end

  always_comb begin
    w_wl = '0;
    if (w_access) w_wl[r_addr] = 1'b1;
  end

  for (genvar u = 0; u < NMU; u++) begin : g_mask
    assign w_mask_full[u*NR +: NR] = {NR{r_umask[u]}};
  end

  assign req_ready_o     = (r_state == ST_IDLE);
  assign rsp_valid_o     = (r_state == ST_RESP);
  assign rsp_rdata_o     = r_rdata;
  assign rsp_err_o       = r_err;
  assign sft_fwd_o       = w_fwd;
  assign sft_bwd_o       = w_bwd;
  assign word_lines_o    = w_wl;
  assign write_en_data_o = w_access & (r_op == OP_WRITE);
  assign write_data_o    = r_wdata;
  assign write_mask_o    = write_en_data_o ? w_mask_full : '0;
  assign rd_current_o    = w_access & (r_op != OP_WRITE);

`ifdef RT_LIM_EN
  assign lim_en_o    = w_access & r_op[1];
  assign nand_norn_o = w_access & (r_op == OP_LIM_NAND);
`else
  assign lim_en_o    = 1'b0;
  assign nand_norn_o = 1'b0;
`endif

endmodule

// File: tb/tb_rt_block_seq.sv
// Directed bench for rt_block_seq: per-cycle output model plus literal spot checks.
module tb_rt_block_seq;

  localparam int NB  = 32;
  localparam int NP  = 8;
  localparam int NR  = 4;
  localparam int NMU = 8;
  localparam int W   = NR * NMU;
  localparam int AW  = $clog2(NB);
  localparam int L   = NB / NP;

`ifdef RT_LIM_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif

  localparam logic [1:0] RD   = 2'b00;
  localparam logic [1:0] WR   = 2'b01;
  localparam logic [1:0] NAND = 2'b10;
  localparam logic [1:0] NOR  = 2'b11;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           req_valid_i;
  logic           req_ready_o;
  logic [1:0]     req_op_i;
  logic [AW-1:0]  req_addr_i;
  logic [W-1:0]   req_wdata_i;
  logic [NMU-1:0] req_umask_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [W-1:0]   rsp_rdata_o;
  logic           rsp_err_o;
  logic           sft_fwd_o;
  logic           sft_bwd_o;
  logic [NB-1:0]  word_lines_o;
  logic           write_en_data_o;
  logic [W-1:0]   write_data_o;
  logic [W-1:0]   write_mask_o;
  logic           rd_current_o;
  logic           lim_en_o;
  logic           nand_norn_o;
  logic [W-1:0]   array_rdata_i;

  rt_block_seq #(.NB(NB), .NP(NP), .NR(NR), .NMU(NMU)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_umask_i(req_umask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .sft_fwd_o(sft_fwd_o), .sft_bwd_o(sft_bwd_o),
    .word_lines_o(word_lines_o), .write_en_data_o(write_en_data_o),
    .write_data_o(write_data_o), .write_mask_o(write_mask_o),
    .rd_current_o(rd_current_o), .lim_en_o(lim_en_o),
    .nand_norn_o(nand_norn_o), .array_rdata_i(array_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          ready;
    logic          fwd;
    logic          bwd;
    logic [NB-1:0] wl;
    logic          wen;
    logic [W-1:0]  wdata;
    logic [W-1:0]  wmask;
    logic          rdc;
    logic          lim;
    logic          nn;
    logic          rvalid;
    logic [W-1:0]  rdata;
    logic          err;
  } obs_t;

  obs_t exp_o;
  obs_t act_o;
  bit   exp_en = 1'b0;

  int checks = 0;
  int errors = 0;

  int            n_fwd = 0, n_bwd = 0, n_acc = 0, n_lim = 0;
  logic [NB-1:0] last_wl = '0;
  logic [W-1:0]  last_wmask = '0;
  logic [W-1:0]  last_rsp_rdata = '0;
  logic          last_rsp_err = 1'b0;
  logic          last_nn = 1'b0;

  // Model state: racetrack offset plus what the response/data registers should hold.
  int           m_off;
  logic [W-1:0] m_wdata;
  logic [W-1:0] m_rdata;
  logic         m_err;

  always_comb act_o = {req_ready_o, sft_fwd_o, sft_bwd_o, word_lines_o, write_en_data_o,
                       write_data_o, write_mask_o, rd_current_o, lim_en_o, nand_norn_o,
                       rsp_valid_o, rsp_rdata_o, rsp_err_o};

  always @(negedge clk_i) begin
    if (exp_en) begin
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, act_o, exp_o);
      end
      if (sft_fwd_o) n_fwd++;
      if (sft_bwd_o) n_bwd++;
      if (|word_lines_o) begin n_acc++; last_wl = word_lines_o; end
      if (write_en_data_o) last_wmask = write_mask_o;
      if (lim_en_o) begin n_lim++; last_nn = nand_norn_o; end
      if (rsp_valid_o) begin last_rsp_rdata = rsp_rdata_o; last_rsp_err = rsp_err_o; end
    end
  end

  function automatic obs_t base_obs();
    obs_t o = '0;
    o.wdata = m_wdata;
    o.rdata = m_rdata;
    o.err   = m_err;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = base_obs();
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic logic [W-1:0] expand_mask(input logic [NMU-1:0] um);
    logic [W-1:0] m = '0;
    for (int u = 0; u < NMU; u++)
      for (int b = 0; b < NR; b++) m[u*NR + b] = um[u];
    return m;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_off = 0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
  endtask

  task automatic do_txn(input logic [1:0] op, input int addr, input logic [W-1:0] wd,
                        input logic [NMU-1:0] um, input logic [W-1:0] ard, input int waitc);
    int t;
    obs_t o;
    t = addr % L;
    req_op_i = op; req_addr_i = AW'(addr); req_wdata_i = wd; req_umask_i = um;
    array_rdata_i = ard; rsp_ready_i = 1'b0; req_valid_i = 1'b1;
    exp_o = idle_obs();
    step();
    req_valid_i = 1'b0;
    m_wdata = wd;
    if (op[1] && !LIM_EN) begin
      m_err = 1'b1;
      m_rdata = '0;
    end else begin
      m_err = 1'b0;
      while (m_off != t) begin
        o = base_obs();
        o.fwd = (t > m_off);
        o.bwd = (t < m_off);
        exp_o = o;
        step();
        m_off += (t > m_off) ? 1 : -1;
      end
      o = base_obs();
      o.wl[addr] = 1'b1;
      o.wen   = (op == WR);
      o.wmask = (op == WR) ? expand_mask(um) : '0;
      o.rdc   = (op != WR);
      o.lim   = LIM_EN && op[1];
      o.nn    = LIM_EN && (op == NAND);
      exp_o = o;
      step();
      if (op != WR) begin
        exp_o = base_obs();
        step();
        m_rdata = ard;
      end
    end
    for (int i = 0; i < waitc; i++) begin
      o = base_obs(); o.rvalid = 1'b1; exp_o = o;
      step();
    end
    o = base_obs(); o.rvalid = 1'b1; exp_o = o;
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    exp_o = idle_obs();
  endtask

  int f0, b0, a0, l0;
  obs_t o;

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0;
    req_wdata_i = '0; req_umask_i = '0; rsp_ready_i = 1'b0; array_rdata_i = '0;
    exp_o = '0;
    step(); step();
    rst_i = 1'b0;
    model_reset();
    exp_o = idle_obs();
    exp_en = 1'b1;
    step();

    // READ addr 6 from offset 0: two forward steps.
    f0 = n_fwd;
    do_txn(RD, 6, 32'h1111_0000, 8'hFF, 32'hA5A5_1234, 0);
    chk("read6_fwd_pulses", 64'(n_fwd - f0), 2);
    chk("read6_wordline", 64'(last_wl), 64'h40);
    chk("read6_rdata", 64'(last_rsp_rdata), 64'hA5A5_1234);
    chk("read6_model_off", 64'(m_off), 2);

    // Move to offset 3, then WRITE addr 8 needs three backward steps.
    do_txn(RD, 7, 32'h0, 8'h00, 32'h0BAD_F00D, 0);
    b0 = n_bwd;
    do_txn(WR, 8, 32'hDEAD_BEEF, 8'h0D, 32'hFFFF_FFFF, 0);
    chk("write8_bwd_pulses", 64'(n_bwd - b0), 3);
    chk("write8_mask", 64'(last_wmask), 64'h0000_FF0F);
    chk("write8_rdata_kept", 64'(last_rsp_rdata), 64'h0BAD_F00D);

    // Same segment offset twice: second access needs no shift; slow response consumer.
    do_txn(RD, 10, 32'h0, 8'h00, 32'h1357_9BDF, 0);
    f0 = n_fwd; b0 = n_bwd; a0 = n_acc;
    do_txn(RD, 14, 32'h0, 8'h00, 32'h2468_ACE0, 5);
    chk("read14_shift_pulses", 64'((n_fwd - f0) + (n_bwd - b0)), 0);
    chk("read14_access_cycles", 64'(n_acc - a0), 1);
    chk("read14_rdata", 64'(last_rsp_rdata), 64'h2468_ACE0);

    do_txn(WR, 5, 32'hCAFE_0001, 8'h00, 32'h0, 1);
    chk("write_um0_mask", 64'(last_wmask), 64'h0);
    chk("write_um0_err", 64'(last_rsp_err), 0);

    l0 = n_lim; a0 = n_acc;
    do_txn(NOR, 3, 32'h0, 8'hFF, 32'h8000_0001, 0);
`ifdef RT_LIM_EN
    chk("nor_lim_pulses", 64'(n_lim - l0), 1);
    chk("nor_nand_norn", 64'(last_nn), 0);
    chk("nor_err", 64'(last_rsp_err), 0);
    chk("nor_rdata", 64'(last_rsp_rdata), 64'h8000_0001);
    do_txn(NAND, 0, 32'h0, 8'hFF, 32'h0000_0042, 0);
    chk("nand_nand_norn", 64'(last_nn), 1);
`else
    chk("nor_err", 64'(last_rsp_err), 1);
    chk("nor_no_access", 64'(n_acc - a0), 0);
    chk("nor_rdata_zero", 64'(last_rsp_rdata), 64'h0);
    chk("nor_no_lim", 64'(n_lim - l0), 0);
    do_txn(NAND, 0, 32'h0, 8'hFF, 32'h0000_0042, 0);
    chk("nand_err", 64'(last_rsp_err), 1);
`endif

    // Reset on the second of three forward steps.
    do_txn(RD, 0, 32'h0, 8'h00, 32'h5555_AAAA, 0);
    f0 = n_fwd;
    req_op_i = RD; req_addr_i = AW'(3); req_wdata_i = 32'h7777_7777; req_valid_i = 1'b1;
    exp_o = idle_obs();
    step();
    req_valid_i = 1'b0;
    m_wdata = 32'h7777_7777; m_err = 1'b0;
    o = base_obs(); o.fwd = 1'b1; exp_o = o;
    step();
    m_off = 1;
    o = base_obs(); o.fwd = 1'b1; exp_o = o;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    model_reset();
    exp_o = idle_obs();
    step();
    chk("midshift_fwd_pulses", 64'(n_fwd - f0), 2);

    f0 = n_fwd;
    do_txn(RD, 1, 32'h0, 8'h00, 32'h0F0F_0F0F, 0);
    chk("post_reset_fwd_pulses", 64'(n_fwd - f0), 1);

    exp_o = idle_obs();
    step(); step();
    exp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
